rect_draw_arbiter: RTL and testbench
====================================

Name: rect_draw_arbiter

Overview:
- Shares the single VGA pixel-write port (x, y, colour, plot) between several game-object drawers, such as the screen clear, paddle, ball and blocks.
- Each requester submits one filled-rectangle descriptor.
- The block arbitrates round-robin, latches the winning descriptor, and emits one pixel per clock in raster order. It clips off-screen pixels and pulses done to the owner.
- It sits between the game FSM and vga_adapter (160x120, 3-bit colour).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SCREEN_W, 160, pixel columns; x >= SCREEN_W is clipped.
- SCREEN_H, 120, pixel rows; y >= SCREEN_H is clipped.

Ports:
- clock  in  1  system clock (CLOCK_50 domain); the only clock.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester; hold high until grant is seen.
- rect_x  in  8*NUM_REQ  left column; requester i uses [8i+7:8i].
- rect_y  in  7*NUM_REQ  top row; requester i uses [7i+6:7i].
- rect_w  in  8*NUM_REQ  width in pixels (0..255).
- rect_h  in  7*NUM_REQ  height in pixels (0..127).
- rect_colour  in  3*NUM_REQ  fill colour.
- grant  out  NUM_REQ  one-hot; high for the whole service of that requester.
- done  out  NUM_REQ  one-cycle pulse to the requester whose rectangle finished.
- busy  out  1  high whenever state != IDLE.
- x  out  8  pixel column to vga_adapter.
- y  out  7  pixel row to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  write enable to vga_adapter.

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-low on resetn.
- Reset values: state=IDLE, grant=0, done=0, busy=0, plot=0, x=0, y=0, colour=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has highest priority first. cx=cy=0.
- States: IDLE, DRAW, DONE.
- IDLE:
  - If any req bit is high, select the winner as the first set bit searching last+1, last+2, ... (mod NUM_REQ), wrapping back to last.
  - On the next edge, latch the winner's rx, ry, rw, rh, rcol and set owner=winner, last=winner, cx=cy=0.
  - If rw==0 or rh==0, go to DONE; otherwise go to DRAW.
  - If no req is high, stay in IDLE.
- DRAW:
  - One pixel per cycle.
  - Pixel address: px = rx+cx (9-bit sum), py = ry+cy (8-bit sum).
  - plot = (px < SCREEN_W) && (py < SCREEN_H).
  - When plot=1: x=px[7:0], y=py[6:0], colour=rcol.
  - When plot=0: x, y and colour are driven 0. A clipped pixel still consumes its cycle.
  - Raster order: if cx==rw-1, then cx=0 and cy=cy+1; otherwise cx=cx+1.
  - When cx==rw-1 and cy==rh-1, next state is DONE.
- DONE:
  - done[owner]=1 for exactly this cycle; next state is IDLE.
  - During DONE, plot=0 and x, y, colour are 0.
- grant[owner] is high in DRAW and DONE, and low in IDLE.
- busy is high in DRAW and DONE.
- Outputs x, y, colour, plot, grant, done and busy are functions of registered state only. There is no combinational path from inputs.
- Timing: let T be the IDLE cycle in which req is sampled high.
  - Grant rises at T+1.
  - DRAW occupies T+1 .. T+rw*rh.
  - done pulses at T+1+rw*rh.
  - For a zero-area rectangle, grant and done are both high at T+1.
  - The earliest next grant is T+3+rw*rh (one IDLE arbitration cycle).
- Handshake:
  - The descriptor is latched on entry to DRAW/DONE. Requester inputs may change freely after grant rises.
  - Deasserting req during service does not abort the rectangle; it completes and done still pulses.
  - If req is still high in the IDLE after done, it is treated as a new request at lowest priority.
- Simultaneous requests: strictly round-robin; no requester is served twice while another is continuously waiting.
- Wrap-around: px/py are computed wide, so a rectangle past the right or bottom edge is clipped, never wrapped to column or row 0.
- Reset mid-operation: all outputs drop asynchronously and no done is issued. After release, arbitration restarts from requester 0.

Test Plan:
- Reset: resetn=0 for 3 cycles with all req=1 -> grant=0, done=0, busy=0, plot=0, x=y=colour=0; after release, first grant is grant=4'b0001.
- Single rectangle: req[0] with x=10, y=20, w=3, h=2, colour=3'b111 -> grant[0] at T+1; plot high at T+1..T+6 with (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all colour 7; done[0] at T+7; busy falls at T+8.
- Zero area: req[2] with w=0, h=5 -> grant[2] and done[2] both high at T+1 only; plot never high.
- Round-robin: req[0], req[1], req[3] held high, each with a 1x1 rectangle -> grant sequence 0,1,3,0,1,3; each done follows its grant by 1 cycle; 3 cycles between successive grant rises.
- Clipping: x=158, y=119, w=4, h=2 -> 8 DRAW cycles; plot high only for (158,119) and (159,119); done at T+9.
- Async reset mid-draw: a 16x2 rectangle with resetn pulled low at DRAW cycle 5, between clock edges -> plot, grant and busy drop immediately with no done; after release with req held, the rectangle is redrawn from (rx,ry) with all 32 pixels.

Source files
------------

// File: rtl/rect_draw_arbiter.sv
// Round-robin arbiter that owns the VGA pixel-write port and rasterises one filled rectangle
// per grant, one pixel per clock, clipping pixels that fall off the screen.
module rect_draw_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] rect_x,
   input  logic [7*NUM_REQ-1:0] rect_y,
   input  logic [8*NUM_REQ-1:0] rect_w,
   input  logic [7*NUM_REQ-1:0] rect_h,
   input  logic [3*NUM_REQ-1:0] rect_colour,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic                 busy,
   output logic [7:0]           x,
   output logic [6:0]           y,
   output logic [2:0]           colour,
   output logic                 plot
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [8:0]  ScrW = 9'(SCREEN_W);
   localparam logic [7:0]  ScrH = 8'(SCREEN_H);

   typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     owner_q, owner_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [7:0]          rx_q, rx_d;
   logic [6:0]          ry_q, ry_d;
   logic [7:0]          rw_q, rw_d;
   logic [6:0]          rh_q, rh_d;
   logic [2:0]          rcol_q, rcol_d;
   logic [7:0]          cx_q, cx_d;
   logic [6:0]          cy_q, cy_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic                busy_q, busy_d;
   logic                plot_q, plot_d;
   logic [7:0]          x_q, x_d;
   logic [6:0]          y_q, y_d;
   logic [2:0]          colour_q, colour_d;

   logic                found;
   logic [IdxW-1:0]     win;
   logic [8:0]          px;
   logic [7:0]          py;

   // First set request after the last winner, wrapping back round to it.
   always_comb begin
      found = 1'b0;
      win   = last_q;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         if (!found && req[(int'(last_q) + k) % int'(NUM_REQ)]) begin
            found = 1'b1;
            win   = IdxW'((int'(last_q) + k) % int'(NUM_REQ));
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      rw_d    = rw_q;
      rh_d    = rh_q;
      rcol_d  = rcol_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      case (state_q)
         StIdle: begin
            if (found) begin
               owner_d = win;
               last_d  = win;
               rx_d    = rect_x[8*int'(win) +: 8];
               ry_d    = rect_y[7*int'(win) +: 7];
               rw_d    = rect_w[8*int'(win) +: 8];
               rh_d    = rect_h[7*int'(win) +: 7];
               rcol_d  = rect_colour[3*int'(win) +: 3];
               cx_d    = 8'd0;
               cy_d    = 7'd0;
               state_d = (rw_d == 8'd0 || rh_d == 7'd0) ? StDone : StDraw;
            end
         end
         StDraw: begin
            if (cx_q == rw_q - 8'd1) begin
               cx_d = 8'd0;
               cy_d = cy_q + 7'd1;
               if (cy_q == rh_q - 7'd1) state_d = StDone;
            end else begin
               cx_d = cx_q + 8'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are precomputed from next state so they register with no extra latency.
   always_comb begin
      px       = {1'b0, rx_d} + {1'b0, cx_d};
      py       = {1'b0, ry_d} + {1'b0, cy_d};
      busy_d   = (state_d != StIdle);
      grant_d  = '0;
      done_d   = '0;
      if (busy_d) grant_d[owner_d] = 1'b1;
      if (state_d == StDone) done_d[owner_d] = 1'b1;
      plot_d   = (state_d == StDraw) && (px < ScrW) && (py < ScrH);
      x_d      = plot_d ? px[7:0] : 8'd0;
      y_d      = plot_d ? py[6:0] : 7'd0;
      colour_d = plot_d ? rcol_d : 3'd0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         owner_q  <= '0;
         last_q   <= IdxW'(NUM_REQ - 1);
         rx_q     <= '0;
         ry_q     <= '0;
         rw_q     <= '0;
         rh_q     <= '0;
         rcol_q   <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         rx_q     <= rx_d;
         ry_q     <= ry_d;
         rw_q     <= rw_d;
         rh_q     <= rh_d;
         rcol_q   <= rcol_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         plot_q   <= plot_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
      end
   end

   assign grant  = grant_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign plot   = plot_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Bench for rect_draw_arbiter: a pixel scoreboard filled from a rectangle model, plus
// per-scenario cycle-accurate checks of grant, done and busy.
module tb_rect_draw_arbiter;

   logic        clock;
   logic        resetn;
   logic [3:0]  req;
   logic [31:0] rect_x;
   logic [27:0] rect_y;
   logic [31:0] rect_w;
   logic [27:0] rect_h;
   logic [11:0] rect_colour;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   rect_draw_arbiter #(
      .NUM_REQ (4),
      .SCREEN_W(160),
      .SCREEN_H(120)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req        (req),
      .rect_x     (rect_x),
      .rect_y     (rect_y),
      .rect_w     (rect_w),
      .rect_h     (rect_h),
      .rect_colour(rect_colour),
      .grant      (grant),
      .done       (done),
      .busy       (busy),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [3:0] oh(input int i);
      logic [3:0] r;
      r = 4'b0001 << i;
      return r;
   endfunction

   // Reference rasteriser: raster order, wide coordinates, off-screen pixels dropped.
   function automatic void push_rect(input int rx, input int ry, input int rw, input int rh,
                                     input logic [2:0] col);
      pix_t p;
      for (int j = 0; j < rh; j++) begin
         for (int i = 0; i < rw; i++) begin
            if (rx + i < 160 && ry + j < 120) begin
               p.x = 8'(rx + i);
               p.y = 7'(ry + j);
               p.c = col;
               exp_q.push_back(p);
            end
         end
      end
   endfunction

   task automatic set_rect(input int i, input int rx, input int ry, input int rw, input int rh,
                           input logic [2:0] col);
      rect_x[8*i +: 8]      = 8'(rx);
      rect_y[7*i +: 7]      = 7'(ry);
      rect_w[8*i +: 8]      = 8'(rw);
      rect_h[7*i +: 7]      = 7'(rh);
      rect_colour[3*i +: 3] = col;
   endtask

   // Scoreboard: every plotted pixel must match the next modelled pixel.
   always @(negedge clock) begin
      pix_t e;
      if (plot === 1'b1) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL pixel_extra got (%0d,%0d,c%0d) want none", x, y, colour);
         end else begin
            e = exp_q.pop_front();
            if ({x, y, colour} !== {e.x, e.y, e.c})
               $display("FAIL pixel got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                        x, y, colour, e.x, e.y, e.c);
            else n_pass++;
         end
      end else begin
         n_total++;
         if ({plot, x, y, colour} !== 19'd0)
            $display("FAIL idle_pixel got plot=%b x=%0d y=%0d c=%0d want all 0",
                     plot, x, y, colour);
         else n_pass++;
      end
   end

   task automatic apply_reset();
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] eg;
      resetn = 1'b1;
      req    = 4'b1111;
      for (int i = 0; i < 4; i++) set_rect(i, 1 + i, 2 + i, 1, 1, 3'(i + 1));
      #1 resetn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         n_total++;
         if ({grant, done, busy, plot, x, y, colour} !== 28'd0)
            $display("FAIL reset_state c=%0d got g=%b d=%b b=%b p=%b want all 0",
                     c, grant, done, busy, plot);
         else n_pass++;
      end
      resetn = 1'b1;
      push_rect(1, 2, 1, 1, 3'd1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         if (c == 1) req = 4'b0000;
         eg = (c <= 2) ? 4'b0001 : 4'b0000;
         n_total++;
         if ({grant, done, busy} !== {eg, (c == 2) ? 4'b0001 : 4'b0000, c <= 2})
            $display("FAIL reset_first_grant c=%0d got g=%b d=%b b=%b want g=%b",
                     c, grant, done, busy, eg);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      logic [3:0] eg, ed;
      logic       eb;
      int         a = 6;
      set_rect(0, 10, 20, 3, 2, 3'b111);
      push_rect(10, 20, 3, 2, 3'b111);
      req = 4'b0001;
      for (int c = 1; c <= a + 3; c++) begin
         @(negedge clock);
         if (c == 1) req = 4'b0000;
         eg = (c <= a + 1) ? 4'b0001 : 4'b0000;
         ed = (c == a + 1) ? 4'b0001 : 4'b0000;
         eb = (c <= a + 1);
         n_total++;
         if ({grant, done, busy} !== {eg, ed, eb})
            $display("FAIL single_timing c=%0d got g=%b d=%b b=%b want g=%b d=%b b=%b",
                     c, grant, done, busy, eg, ed, eb);
         else n_pass++;
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL single_pixels left=%0d want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_zero_area();
      logic [3:0] eg, ed;
      set_rect(2, 30, 40, 0, 5, 3'b010);
      req = 4'b0100;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         if (c == 1) req = 4'b0000;
         eg = (c == 1) ? 4'b0100 : 4'b0000;
         ed = eg;
         n_total++;
         if ({grant, done, busy, plot} !== {eg, ed, c == 1, 1'b0})
            $display("FAIL zero_area c=%0d got g=%b d=%b b=%b p=%b want g=%b d=%b",
                     c, grant, done, busy, plot, eg, ed);
         else n_pass++;
      end
   endtask

   task automatic test_clip();
      logic [3:0] eg, ed;
      int         a = 8;
      set_rect(1, 158, 119, 4, 2, 3'b101);
      push_rect(158, 119, 4, 2, 3'b101);
      req = 4'b0010;
      for (int c = 1; c <= a + 3; c++) begin
         @(negedge clock);
         if (c == 1) req = 4'b0000;
         eg = (c <= a + 1) ? 4'b0010 : 4'b0000;
         ed = (c == a + 1) ? 4'b0010 : 4'b0000;
         n_total++;
         if ({grant, done, busy} !== {eg, ed, c <= a + 1})
            $display("FAIL clip_timing c=%0d got g=%b d=%b b=%b want g=%b d=%b",
                     c, grant, done, busy, eg, ed);
         else n_pass++;
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL clip_pixels left=%0d want 0", exp_q.size());
      else n_pass++;
   endtask

   // Rectangles that cross column 256 / row 128 must clip, not wrap to 0.
   task automatic test_wrap();
      int wx[2] = '{254, 5};
      int wy[2] = '{50, 118};
      int ww[2] = '{4, 1};
      int wh[2] = '{1, 12};
      for (int r = 0; r < 2; r++) begin
         set_rect(3, wx[r], wy[r], ww[r], wh[r], 3'b011);
         push_rect(wx[r], wy[r], ww[r], wh[r], 3'b011);
         req = 4'b1000;
         for (int c = 1; c <= ww[r] * wh[r] + 3; c++) begin
            @(negedge clock);
            if (c == 1) req = 4'b0000;
            if (c == ww[r] * wh[r] + 1) begin
               n_total++;
               if (done !== 4'b1000) $display("FAIL wrap_done r=%0d got %b want 1000", r, done);
               else n_pass++;
            end
         end
         n_total++;
         if (exp_q.size() != 0) $display("FAIL wrap_pixels r=%0d left=%0d want 0", r, exp_q.size());
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      int         seq[6] = '{0, 1, 3, 0, 1, 3};
      int         k = 0;
      int         rise_c = -10;
      logic [3:0] prev_g = 4'b0000;
      apply_reset();
      for (int i = 0; i < 4; i++) set_rect(i, 40 + i, 60, 1, 1, 3'(i + 1));
      for (int i = 0; i < 6; i++) push_rect(40 + seq[i], 60, 1, 1, 3'(seq[i] + 1));
      req = 4'b1011;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (c == rise_c + 1) begin
            n_total++;
            if (done !== oh(seq[k-1]))
               $display("FAIL rr_done c=%0d got %b want %b", c, done, oh(seq[k-1]));
            else n_pass++;
         end
         if (grant !== 4'b0000 && prev_g === 4'b0000) begin
            n_total++;
            if (k >= 6 || grant !== oh(seq[k]) || c != 1 + 3 * k)
               $display("FAIL rr_grant k=%0d c=%0d got %b want %b at c=%0d",
                        k, c, grant, (k < 6) ? oh(seq[k]) : 4'b0000, 1 + 3 * k);
            else n_pass++;
            rise_c = c;
            k++;
            if (k == 6) req = 4'b0000;
         end
         prev_g = grant;
      end
      n_total++;
      if (k != 6 || exp_q.size() != 0)
         $display("FAIL rr_count got grants=%0d left=%0d want 6 and 0", k, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [3:0] eg, ed;
      int         a = 32;
      set_rect(0, 20, 30, 16, 2, 3'b101);
      push_rect(20, 30, 16, 2, 3'b101);
      req = 4'b0001;
      for (int c = 1; c <= 5; c++) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      n_total++;
      if ({plot, grant, busy, done} !== 10'd0)
         $display("FAIL async_drop got p=%b g=%b b=%b d=%b want all 0", plot, grant, busy, done);
      else n_pass++;
      exp_q.delete();
      push_rect(20, 30, 16, 2, 3'b101);
      @(negedge clock);
      resetn = 1'b1;
      for (int c = 1; c <= a + 3; c++) begin
         @(negedge clock);
         if (c == 1) req = 4'b0000;
         eg = (c <= a + 1) ? 4'b0001 : 4'b0000;
         ed = (c == a + 1) ? 4'b0001 : 4'b0000;
         n_total++;
         if ({grant, done, busy} !== {eg, ed, c <= a + 1})
            $display("FAIL async_redraw c=%0d got g=%b d=%b b=%b want g=%b d=%b",
                     c, grant, done, busy, eg, ed);
         else n_pass++;
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL async_pixels left=%0d want 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      req         = '0;
      rect_x      = '0;
      rect_y      = '0;
      rect_w      = '0;
      rect_h      = '0;
      rect_colour = '0;
      test_reset();
      test_single();
      test_zero_area();
      test_clip();
      test_wrap();
      test_round_robin();
      test_async_reset();
      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
